i2c_cfg_sequencer: RTL

//   Sequences register-write transactions into a byte-level I2C write master (dev/reg/data per command).

---
 rtl/i2c_cfg_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_cfg_sequencer.sv
// I2C configuration sequencer: walks a register table into a byte-level I2C write master,
// retrying NACKed writes with an idle gap, then serves runtime host writes one at a time.
module i2c_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h40,
  parameter int         N_ENTRIES  = 10,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tbl_idx,
  input  logic [15:0] tbl_entry,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [6:0]  m_dev_addr,
  output logic [7:0]  m_reg_addr,
  output logic [7:0]  m_data,
  input  logic        m_done,
  input  logic        m_ack_err,
  input  logic        host_req,
  input  logic [7:0]  host_reg,
  input  logic [7:0]  host_data,
  output logic        host_done,
  output logic        host_err,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [7:0]  err_idx
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GapLast  = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    IdxLast  = 8'(N_ENTRIES - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, ISSUE, WAIT, GAP, READY, HOST_ISSUE, HOST_WAIT, HOST_GAP, FAIL
  } state_t;

  state_t          state_q;
  logic [7:0]      tbl_idx_q;
  logic            m_valid_q;
  logic [7:0]      m_reg_addr_q;
  logic [7:0]      m_data_q;
  logic [RW-1:0]   retry_q;
  logic [GW-1:0]   gap_cnt_q;
  logic            rom_wait_q;
  logic            host_done_q;
  logic            host_err_q;
  logic            init_done_q;
  logic            init_err_q;
  logic [7:0]      err_idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tbl_idx_q    <= '0;
      m_valid_q    <= 1'b0;
      m_reg_addr_q <= '0;
      m_data_q     <= '0;
      retry_q      <= '0;
      gap_cnt_q    <= '0;
      rom_wait_q   <= 1'b0;
      host_done_q  <= 1'b0;
      host_err_q   <= 1'b0;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      err_idx_q    <= '0;
    end else begin
      host_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tbl_idx_q  <= '0;
            retry_q    <= '0;
            rom_wait_q <= 1'b1;
            state_q    <= FETCH;
          end
        end
        // The ROM registers tbl_idx first, so its output is only usable on the second FETCH cycle.
        FETCH: begin
          if (rom_wait_q) begin
            rom_wait_q <= 1'b0;
          end else begin
            m_reg_addr_q <= tbl_entry[15:8];
            m_data_q     <= tbl_entry[7:0];
            m_valid_q    <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE, HOST_ISSUE: begin
          if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= (state_q == ISSUE) ? WAIT : HOST_WAIT;
          end
        end
        WAIT: begin
          if (m_done) begin
            gap_cnt_q <= '0;
            if (!m_ack_err) begin
              retry_q <= '0;
              state_q <= GAP;
            end else if (retry_q < RetryMax) begin
              retry_q <= retry_q + 1'b1;
              state_q <= GAP;
            end else begin
              init_err_q <= 1'b1;
              err_idx_q  <= tbl_idx_q;
              state_q    <= FAIL;
            end
          end
        end
        // A non-zero retry count means the previous write was NACKed and must be re-issued as-is.
        GAP: begin
          if (gap_cnt_q == GapLast) begin
            if (retry_q != '0) begin
              m_valid_q <= 1'b1;
              state_q   <= ISSUE;
            end else if (tbl_idx_q == IdxLast) begin
              init_done_q <= 1'b1;
              state_q     <= READY;
            end else begin
              tbl_idx_q  <= tbl_idx_q + 8'd1;
              rom_wait_q <= 1'b1;
              state_q    <= FETCH;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        READY: begin
          if (host_req) begin
            m_reg_addr_q <= host_reg;
            m_data_q     <= host_data;
            m_valid_q    <= 1'b1;
            retry_q      <= '0;
            state_q      <= HOST_ISSUE;
          end
        end
        HOST_WAIT: begin
          if (m_done) begin
            gap_cnt_q <= '0;
            state_q   <= HOST_GAP;
            if (m_ack_err && (retry_q < RetryMax)) begin
              retry_q <= retry_q + 1'b1;
            end else begin
              retry_q     <= '0;
              host_done_q <= 1'b1;
              host_err_q  <= m_ack_err;
            end
          end
        end
        HOST_GAP: begin
          if (gap_cnt_q == GapLast) begin
            if (retry_q != '0) begin
              m_valid_q <= 1'b1;
              state_q   <= HOST_ISSUE;
            end else begin
              state_q <= READY;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        FAIL:    state_q <= FAIL;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tbl_idx    = tbl_idx_q;
  assign m_valid    = m_valid_q;
  assign m_dev_addr = DEV_ADDR;
  assign m_reg_addr = m_reg_addr_q;
  assign m_data     = m_data_q;
  assign host_done  = host_done_q;
  assign host_err   = host_err_q;
  assign busy       = (state_q != IDLE) && (state_q != READY) && (state_q != FAIL);
  assign init_done  = init_done_q;
  assign init_err   = init_err_q;
  assign err_idx    = err_idx_q;

endmodule
